// File: rtl/pwm_led_array_pkg.sv
// Shared types, defaults and helpers for the N-channel PWM LED driver.
// Duty clamping and divider sizing live here so every channel agrees on them.
package led_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NCH_DEF      = 3;
    localparam int CW_DEF       = 8;
    localparam int PERIOD_DEF   = 100;
    localparam int FADE_DIV_DEF = 4;

    // Width of the frame divider that counts 0..fadeDiv-1.
    function automatic int div_width(input int fadeDiv);
        return $clog2(fadeDiv + 1);
    endfunction

    function automatic logic [31:0] sat_duty(input logic [31:0] value, input logic [31:0] period);
        logic [31:0] result;
        if (value > period) begin
            result = period;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_led_array_if.sv
// Control/status bundle between the board control logic and the PWM LED driver.
interface pwm_led_array_if
    import led_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
);
    logic                en;
    logic [NCH*CW-1:0]   target;
    logic                load;
    logic                fade_en;
    logic [NCH-1:0]      pwm_out;
    logic                busy;
    logic                frame_tick;

    modport master (
        output en, target, load, fade_en,
        input  pwm_out, busy, frame_tick
    );

    modport slave (
        input  en, target, load, fade_en,
        output pwm_out, busy, frame_tick
    );
endinterface

// File: rtl/pwm_led_array_channel.sv
// One PWM channel: clamped target register, current duty with jump/fade update
// at frame boundaries, and the registered output comparator.
module pwm_channel
    import led_pkg::*;
#(
    parameter int CW     = CW_DEF,
    parameter int PERIOD = PERIOD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [CW-1:0] cnt,
    input  logic          boundary,
    input  logic          fadeStep,
    input  logic          fade_en,
    input  logic          load,
    input  logic [CW-1:0] target,
    output logic          pwm,
    output logic          busy
);

    logic [CW-1:0] tgt_r;
    logic [CW-1:0] cur_r;
    logic          pwm_r;
    logic [CW-1:0] tgtNext_s;
    logic [CW-1:0] stepped_s;
    logic [CW-1:0] curNext_s;

    // Target capture with clamp to a full-on duty.
    always_comb begin
        tgtNext_s = tgt_r;
        if (load) begin
            tgtNext_s = CW'(sat_duty(32'(target), 32'(PERIOD)));
        end else begin
            tgtNext_s = tgt_r;
        end
    end

    // One-count move toward the target used by the fade ramp.
    always_comb begin
        stepped_s = cur_r;
        if (cur_r < tgt_r) begin
            stepped_s = cur_r + CW'(1);
        end else if (cur_r > tgt_r) begin
            stepped_s = cur_r - CW'(1);
        end else begin
            stepped_s = cur_r;
        end
    end

    // Current duty only changes at a frame boundary, so a frame never mixes duties.
    always_comb begin
        curNext_s = cur_r;
        if (!run) begin
            curNext_s = '0;
        end else if (fadeStep) begin
            curNext_s = stepped_s;
        end else if (boundary && !fade_en) begin
            curNext_s = tgt_r;
        end else begin
            curNext_s = cur_r;
        end
    end

    // Channel registers; the comparator sees the old duty on the boundary edge,
    // so a full-on duty never drops low across the wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tgt_r <= '0;
            cur_r <= '0;
            pwm_r <= 1'b0;
        end else begin
            tgt_r <= tgtNext_s;
            cur_r <= curNext_s;
            pwm_r <= run && (cnt < cur_r);
        end
    end

    assign pwm  = pwm_r;
    assign busy = (cur_r != tgt_r);

endmodule

// File: rtl/pwm_led_array.sv
// N-channel PWM LED driver: run/idle control, frame counter, fade divider and
// status, with one pwm_channel per LED.
module pwm_led_array
    import led_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int CW       = CW_DEF,
    parameter int PERIOD   = PERIOD_DEF,
    parameter int FADE_DIV = FADE_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_led_array_if.slave       bus
);

    localparam int            DW       = div_width(FADE_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(FADE_DIV - 1);

    state_t         state_r;
    state_t         stateNext_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cntNext_s;
    logic [DW-1:0]  div_r;
    logic [DW-1:0]  divNext_s;
    logic           frameTick_r;
    logic           run_s;
    logic           boundary_s;
    logic           fadeStep_s;
    logic [NCH-1:0] chPwm_s;
    logic [NCH-1:0] chBusy_s;

    // Run/idle decision; en low wins immediately, mid-frame or not.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.en) begin
                    stateNext_s = RUN;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = RUN;
                end
            end
            default: stateNext_s = IDLE;
        endcase
    end

    assign run_s      = (stateNext_s == RUN);
    assign boundary_s = (state_r == RUN) && (cnt_r == CNT_LAST);
    assign fadeStep_s = boundary_s && bus.fade_en && (div_r == DIV_LAST);

    // Frame counter and fade divider; both restart from zero on every entry to RUN.
    always_comb begin
        cntNext_s = cnt_r;
        divNext_s = div_r;
        if (!run_s || (state_r == IDLE)) begin
            cntNext_s = '0;
            divNext_s = '0;
        end else if (boundary_s) begin
            cntNext_s = '0;
            if (bus.fade_en) begin
                if (div_r == DIV_LAST) begin
                    divNext_s = '0;
                end else begin
                    divNext_s = div_r + DW'(1);
                end
            end else begin
                divNext_s = div_r;
            end
        end else begin
            cntNext_s = cnt_r + CW'(1);
            divNext_s = div_r;
        end
    end

    // Control registers; the tick is derived from the next count so it lines up with cnt==PERIOD-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            div_r       <= '0;
            frameTick_r <= 1'b0;
        end else begin
            state_r     <= stateNext_s;
            cnt_r       <= cntNext_s;
            div_r       <= divNext_s;
            frameTick_r <= run_s && (cntNext_s == CNT_LAST);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_channel #(
            .CW     (CW),
            .PERIOD (PERIOD)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .run      (run_s),
            .cnt      (cnt_r),
            .boundary (boundary_s),
            .fadeStep (fadeStep_s),
            .fade_en  (bus.fade_en),
            .load     (bus.load),
            .target   (bus.target[i*CW +: CW]),
            .pwm      (chPwm_s[i]),
            .busy     (chBusy_s[i])
        );
    end

    assign bus.pwm_out    = chPwm_s;
    assign bus.busy       = (state_r == RUN) && (|chBusy_s);
    assign bus.frame_tick = frameTick_r;

endmodule

// File: tb/tb_pwm_led_array.sv
// Self-checking bench for pwm_led_array (NCH=3, CW=8, PERIOD=10, FADE_DIV=2):
// per-cycle scoreboard against a behavioural model, vector table and directed sequences.
module tb_pwm_led_array;

    localparam int NCH      = 3;
    localparam int CW       = 8;
    localparam int PERIOD   = 10;
    localparam int FADE_DIV = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pwm_led_array_if #(.NCH(NCH), .CW(CW)) bus ();

    pwm_led_array #(
        .NCH      (NCH),
        .CW       (CW),
        .PERIOD   (PERIOD),
        .FADE_DIV (FADE_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] pwm;
        logic       busy;
        logic       tick;
    } exp_t;

    typedef struct {
        logic        r;
        logic        e;
        logic        l;
        logic        f;
        logic [23:0] t;
        int          n;
        logic [2:0]  pwm;
        logic [2:0]  mask;
        logic        busy;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[4];
    int   checks = 0;
    int   errors = 0;
    int   cycNo  = 0;

    // behavioural model state
    logic mRun;
    int   mCnt, mDiv;
    int   mTgt[NCH];
    int   mCur[NCH];
    logic [2:0] mPwm;
    logic mTick;

    logic [2:0]  obsPwm;
    logic        obsBusy, obsTick;
    logic        hEn, hFade;
    logic [23:0] hTgt;
    int          hi[NCH];
    int          ticks;
    int          fadeExp[8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
    int          rtExp[10]   = '{0, 0, 1, 1, 2, 2, 1, 1, 0, 0};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cycNo, act, exp);
        end
    endtask

    task automatic modelEdge(input logic r, input logic e, input logic l, input logic f,
                             input logic [23:0] t);
        int   nTgt[NCH];
        logic bnd;
        logic wrap;
        for (int i = 0; i < NCH; i++) begin
            if (l) nTgt[i] = (int'(t[i*CW +: CW]) > PERIOD) ? PERIOD : int'(t[i*CW +: CW]);
            else   nTgt[i] = mTgt[i];
        end
        if (!r) begin
            mRun = 1'b0; mCnt = 0; mDiv = 0; mPwm = 3'b000; mTick = 1'b0;
            for (int i = 0; i < NCH; i++) begin mTgt[i] = 0; mCur[i] = 0; end
        end else if (!e) begin
            mRun = 1'b0; mCnt = 0; mDiv = 0; mPwm = 3'b000; mTick = 1'b0;
            for (int i = 0; i < NCH; i++) begin mCur[i] = 0; mTgt[i] = nTgt[i]; end
        end else if (!mRun) begin
            mRun = 1'b1; mCnt = 0; mPwm = 3'b000; mTick = 1'b0;
            for (int i = 0; i < NCH; i++) mTgt[i] = nTgt[i];
        end else begin
            bnd = (mCnt == PERIOD - 1);
            for (int i = 0; i < NCH; i++) mPwm[i] = (mCnt < mCur[i]);
            if (bnd) begin
                if (f) begin
                    wrap = (mDiv == FADE_DIV - 1);
                    mDiv = wrap ? 0 : mDiv + 1;
                    if (wrap) begin
                        for (int i = 0; i < NCH; i++) begin
                            if (mCur[i] < mTgt[i])      mCur[i]++;
                            else if (mCur[i] > mTgt[i]) mCur[i]--;
                        end
                    end
                end else begin
                    for (int i = 0; i < NCH; i++) mCur[i] = mTgt[i];
                end
            end
            mCnt  = bnd ? 0 : mCnt + 1;
            mTick = (mCnt == PERIOD - 1);
            for (int i = 0; i < NCH; i++) mTgt[i] = nTgt[i];
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic l, input logic f,
                       input logic [23:0] t);
        exp_t ex;
        @(negedge clk);
        rst = r; bus.en = e; bus.load = l; bus.fade_en = f; bus.target = t;
        modelEdge(r, e, l, f, t);
        ex.pwm  = mPwm;
        ex.tick = mTick;
        ex.busy = 1'b0;
        for (int i = 0; i < NCH; i++) if (mRun && (mCur[i] != mTgt[i])) ex.busy = 1'b1;
        sbq.push_back(ex);
        @(posedge clk);
        #1;
        cycNo++;
        obsPwm  = bus.pwm_out;
        obsBusy = bus.busy;
        obsTick = bus.frame_tick;
        ex = sbq.pop_front();
        check("sb_pwm_out", 32'(obsPwm), 32'(ex.pwm));
        check("sb_busy", 32'(obsBusy), 32'(ex.busy));
        check("sb_frame_tick", 32'(obsTick), 32'(ex.tick));
    endtask

    task automatic run1();
        cyc(1'b1, hEn, 1'b0, hFade, hTgt);
    endtask

    task automatic ld(input logic [23:0] t);
        hTgt = t;
        cyc(1'b1, hEn, 1'b1, hFade, t);
    endtask

    // Align to a frame start, then count highs/ticks over one frame.
    task automatic measureFrame(input int loadAt, input logic [23:0] lt);
        for (int k = 0; k < PERIOD && mCnt != 0; k++) run1();
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        ticks = 0;
        for (int k = 0; k < PERIOD; k++) begin
            if (k == loadAt) ld(lt);
            else run1();
            for (int i = 0; i < NCH; i++) if (obsPwm[i]) hi[i]++;
            if (obsTick) ticks++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int total;
        rst = 1'b0; bus.en = 1'b0; bus.load = 1'b0; bus.fade_en = 1'b0; bus.target = '0;
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 3,  3'b000, 3'b111, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 5,  3'b000, 3'b111, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h05000A, 3,  3'b000, 3'b111, 1'b0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 24'h05000A, 25, 3'b001, 3'b011, 1'b0};

        for (int p = 0; p < 4; p++) begin
            hEn = vt[p].e; hFade = vt[p].f; hTgt = vt[p].t;
            cyc(vt[p].r, vt[p].e, vt[p].l, vt[p].f, vt[p].t);
            for (int k = 1; k < vt[p].n; k++) cyc(vt[p].r, vt[p].e, 1'b0, vt[p].f, vt[p].t);
            check($sformatf("vec%0d_pwm", p), 32'(obsPwm & vt[p].mask), 32'(vt[p].pwm));
            check($sformatf("vec%0d_busy", p), 32'(obsBusy), 32'(vt[p].busy));
        end

        // jump mode: full, off and half duty, one tick per frame
        for (int fr = 0; fr < 2; fr++) begin
            measureFrame(-1, 24'h0);
            check("jump_ch0_high", hi[0], 10);
            check("jump_ch1_high", hi[1], 0);
            check("jump_ch2_high", hi[2], 5);
            check("jump_ticks", ticks, 1);
        end

        // saturation: 200 stores as 10, which equals the current duty
        ld(24'h0500C8);
        check("sat_busy_load", 32'(obsBusy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            run1();
            check("sat_busy", 32'(obsBusy), 32'd0);
        end
        total = 0;
        for (int fr = 0; fr < 3; fr++) begin
            measureFrame(-1, 24'h0);
            total += hi[0];
        end
        check("sat_ch0_no_glitch", total, 30);

        // mid-frame disable at cnt=4
        for (int k = 0; k < PERIOD && mCnt != 4; k++) run1();
        check("pre_disable_ch0", 32'(obsPwm[0]), 32'd1);
        hEn = 1'b0;
        run1();
        check("disable_pwm", 32'(obsPwm), 32'd0);
        check("disable_busy", 32'(obsBusy), 32'd0);

        // fade up 0 -> 3 on ch2, one step every second boundary
        hFade = 1'b1;
        ld(24'h030000);
        hEn = 1'b1;
        run1();
        for (int fr = 0; fr < 8; fr++) begin
            measureFrame(-1, 24'h0);
            check($sformatf("fade_ch2_f%0d", fr), hi[2], fadeExp[fr]);
            if (fr == 4) check("fade_busy_f4", 32'(obsBusy), 32'd1);
            if (fr == 5) check("fade_busy_f5", 32'(obsBusy), 32'd0);
        end

        // retarget to 0 at duty 2 during a 0 -> 5 ramp
        hEn = 1'b0;
        ld(24'h050000);
        hEn = 1'b1;
        run1();
        for (int fr = 0; fr < 10; fr++) begin
            measureFrame((fr == 4) ? 3 : -1, 24'h000000);
            check($sformatf("retarget_ch2_f%0d", fr), hi[2], rtExp[fr]);
        end

        // mid-frame synchronous reset while busy
        hFade = 1'b0;
        ld(24'h05000A);
        measureFrame(-1, 24'h0);
        measureFrame(-1, 24'h0);
        check("rst_setup_ch2", hi[2], 5);
        hFade = 1'b1;
        ld(24'h08000A);
        for (int k = 0; k < PERIOD && mCnt != 4; k++) run1();
        check("pre_rst_busy", 32'(obsBusy), 32'd1);
        check("pre_rst_ch0", 32'(obsPwm[0]), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, hTgt);
        check("rst_pwm", 32'(obsPwm), 32'd0);
        check("rst_busy", 32'(obsBusy), 32'd0);
        check("rst_tick", 32'(obsTick), 32'd0);
        hEn = 1'b0;
        run1();
        check("post_rst_pwm", 32'(obsPwm), 32'd0);
        check("scoreboard_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
